maxpool_2x2_stream: RTL and testbench
=====================================

# maxpool_2x2_stream

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU activation in the CNN datapath. It consumes one activation per accepted beat in raster order (W pixels per row, H rows per frame) and emits one pooled value per 2×2 window, also in raster order, W/2 × H/2 per frame. A single half-row line buffer holds the horizontal pair maxima of each even row until the matching odd row arrives.

## Interface
Parameters:
- N, 16, data width in bits, matching the ReLU width; values are two's-complement signed.
- W, 28, input row length in pixels; must be even and ≥ 2.
- H, 28, input rows per frame; must be even and ≥ 2.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all control state.
- in_valid, input, 1, upstream beat present.
- in_data, input, N, activation value from the ReLU stage.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- out_valid, output, 1, pooled value present.
- out_data, output, N, pooled maximum.
- out_ready, input, 1, downstream accepts when out_valid && out_ready.
- frame_done, output, 1, one-cycle pulse after the last output of a frame is accepted.

## Operation
- Counters: col (0..W-1) and row (0..H-1) advance on each accepted input. col wraps to 0 at W-1, and row increments at that point. row wraps to 0 at H-1/W-1 (end of frame).
- Row-phase FSM has two states:
  - ROW_A (even row): on even col, register pair_max = in_data. On odd col, write max(pair_max, in_data) to line_buf[col>>1].
  - ROW_B (odd row): on even col, register pair_max. On odd col, load out_data = max(pair_max, in_data, line_buf[col>>1]) and set out_valid.
  - ROW_A→ROW_B and ROW_B→ROW_A transitions happen on acceptance of col = W-1.
- All comparisons are signed N-bit. When values are equal, the result is that value; no tie-breaking is observable.
- in_ready = !out_valid || out_ready. Input stalls whenever an unaccepted output is held, including on beats that would not produce an output.
- out_valid clears on handshake unless a new result is loaded in the same cycle, in which case it stays high with the new data.
- frame_done pulses for one cycle, the cycle after the handshake of the (H/2-1, W/2-1) output.
- Reset mid-frame discards the partial frame and any held output. Pooling restarts at row 0, col 0, in ROW_A.
- Line buffer contents are not reset. Every entry is written in ROW_A before it is read in ROW_B.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - frame_done = 0
  - col = row = 0
  - FSM = ROW_A
- Latency: out_valid rises the cycle after the odd-row, odd-column input is accepted.
- Throughput: one input per cycle when out_ready is held high; no bubbles at row or frame boundaries.
- out_data and out_valid are stable while out_valid && !out_ready.
- Line buffer read in ROW_B is combinational or synchronous. If synchronous, the read is issued on the even-col beat so the value is ready at the odd-col beat; latency is unchanged.
- Simultaneous output handshake and new result in the same cycle is legal: the new value is presented on the next cycle.

## Structure
- Shared package cnn_pkg holds:
  - the data-width constant (shared with relu)
  - the signed max helper function
  - the row-phase enum {ROW_A, ROW_B}
- Sub-module pool_line_buffer is a W/2-deep, N-wide, single-write/single-read array with no reset. It maps to distributed RAM.
- Top-level logic consists of counters, the FSM, pair register, comparators and the output register.

## Test plan
All cases use W=4, H=4.
- Basic: rows [1,5,2,3], [4,0,7,6], [9,8,1,1], [2,2,3,10] with out_ready=1 → outputs 5, 7, 9, 10; frame_done pulses once after the 10 is accepted.
- Signed: window 0xFFFD, 0xFFFE / 0xFFFF, 0xFFFC → output 0xFFFF. A window mixing 0x7FFF and 0x8000 → output 0x7FFF.
- Backpressure: hold out_ready=0 after the first output.
  - Required: out_data stays 5, in_ready goes 0, and no input is lost.
  - On release, the remaining outputs are 7, 9, 10 in order.
- Back-to-back frames: two frames streamed with no gap → 8 outputs in order and two frame_done pulses. The second frame's first window must not use first-frame buffer data.
- Reset mid-frame: assert reset after 6 beats, then stream a full frame → only that frame's 4 correct outputs appear, and out_valid=0 during reset.
- Random in_valid/out_ready toggling over 50 frames checked against a reference model → no mismatches or drops.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: activation width, signed max helper and the
// pooling row-phase encoding.
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    ROW_A = 1'b0,
    ROW_B = 1'b1
  } row_phase_t;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row store of even-row pair maxima; combinational read so it maps to
// distributed RAM. Contents are never reset: every entry is rewritten before use.
module pool_line_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pooling over a W x H raster frame.
// Even rows park pair maxima in the line buffer; odd rows finish each window.
module maxpool_2x2_stream
  import cnn_pkg::*;
#(
  parameter int N = DATA_W,  // the shared smax helper is DATA_W wide
  parameter int W = 28,
  parameter int H = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic         frame_done
);

  localparam int CW = $clog2(W);
  localparam int RW = (H > 2) ? $clog2(H) : 1;
  localparam int AW = (W > 2) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  row_phase_t    state_q, state_d;
  logic [N-1:0]  pair_q, pair_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q, last_d;
  logic          frame_done_q, frame_done_d;

  logic          accept;
  logic          out_fire;
  logic          lb_we;
  logic [N-1:0]  lb_wdata;
  logic [N-1:0]  lb_rdata;
  logic [AW-1:0] lb_addr;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign lb_addr    = AW'(col_q >> 1);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

  pool_line_buffer #(
    .N     (N),
    .DEPTH (W / 2),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    pair_d       = pair_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready;
    last_d       = last_q;
    // last_q tags the held output, so this fires the cycle after its handshake
    frame_done_d = out_fire && last_q;
    lb_we        = 1'b0;
    lb_wdata     = smax(pair_q, in_data);

    if (accept) begin
      if (!col_q[0]) begin
        pair_d = in_data;
      end else if (state_q == ROW_A) begin
        lb_we = 1'b1;
      end else begin
        out_data_d  = smax(smax(pair_q, in_data), lb_rdata);
        out_valid_d = 1'b1;
        last_d      = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end

      if (col_q == COL_LAST) begin
        col_d   = '0;
        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        state_d = (state_q == ROW_A) ? ROW_B : ROW_A;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= ROW_A;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Scoreboard bench for maxpool_2x2_stream: a frame-array reference model queues
// expected window maxima, an independent monitor pops them on each handshake.
module tb_maxpool_2x2_stream;

  localparam int N = 16;
  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  typedef struct {
    logic [N-1:0] data;
    bit           last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int rdy_mode    = 0;   // 0: always ready, 1: random, 2: held low
  int fd_count    = 0;

  exp_t         exp_q[$];
  logic [N-1:0] got_log[$];
  logic [N-1:0] frame_px [H][W];
  int           m_row = 0;
  int           m_col = 0;
  bit           fd_pending = 1'b0;
  bit           prev_hold  = 1'b0;
  logic [N-1:0] prev_data  = '0;

  maxpool_2x2_stream #(.N(N), .W(W), .H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Maximum of the 2x2 window whose top-left pixel is (r, c), signed compare
  function automatic logic [N-1:0] window_max(input int r, input int c);
    logic signed [N-1:0] best;
    best = frame_px[r][c];
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if ($signed(frame_px[r+dy][c+dx]) > best) best = frame_px[r+dy][c+dx];
    return best;
  endfunction

  // Reference model: track accepted pixels by raster position
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_row = 0;
      m_col = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      frame_px[m_row][m_col] = in_data;
      if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
        e.data = window_max(m_row - 1, m_col - 1);
        e.last = (m_row == H - 1) && (m_col == W - 1);
        exp_q.push_back(e);
      end
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row + 1) % H;
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("out_valid_in_reset", 32'(out_valid), 32'd0);
      fd_pending = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (frame_done || fd_pending) check("frame_done", 32'(frame_done), 32'(fd_pending));
      if (frame_done) fd_count++;
      fd_pending = 1'b0;
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        got_log.push_back(out_data);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %0h, required no output", out_data);
        end else begin
          e = exp_q.pop_front();
          $display("out %04h expected %04h", out_data, e.data);
          check("out_data", 32'(out_data), 32'(e.data));
          if (e.last) fd_pending = 1'b1;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // Downstream ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [N-1:0] d, input int gap_pct);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    while ($urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waited++;
        if (waited > 500) begin
          vectors++;
          miscompares++;
          $display("FAIL send_timeout: got in_ready 0 for 500 cycles, required acceptance");
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] px [NPIX], input int gap_pct);
    for (int i = 0; i < NPIX; i++) send(px[i], gap_pct);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [N-1:0] basic_px  [NPIX];
  logic [N-1:0] signed_px [NPIX];
  logic [N-1:0] rand_px   [NPIX];

  initial begin
    int n;
    basic_px  = '{1, 5, 2, 3, 4, 0, 7, 6, 9, 8, 1, 1, 2, 2, 3, 10};
    signed_px = '{16'hFFFD, 16'hFFFE, 16'h7FFF, 16'h8000,
                  16'hFFFF, 16'hFFFC, 16'h8000, 16'h8000,
                  16'h0003, 16'h8001, 16'hFFFF, 16'h0000,
                  16'h8000, 16'h0002, 16'h0001, 16'hFFFF};
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;

    // Basic frame
    got_log.delete();
    fd_count = 0;
    send_frame(basic_px, 0);
    drain(100);
    check("basic_count", 32'(got_log.size()), 32'd4);
    if (got_log.size() == 4) begin
      check("basic_0", 32'(got_log[0]), 32'd5);
      check("basic_1", 32'(got_log[1]), 32'd7);
      check("basic_2", 32'(got_log[2]), 32'd9);
      check("basic_3", 32'(got_log[3]), 32'd10);
    end
    check("basic_frame_done", 32'(fd_count), 32'd1);

    // Signed windows
    got_log.delete();
    send_frame(signed_px, 0);
    drain(100);
    check("signed_count", 32'(got_log.size()), 32'd4);
    if (got_log.size() == 4) begin
      check("signed_neg", 32'(got_log[0]), 32'hFFFF);
      check("signed_ext", 32'(got_log[1]), 32'h7FFF);
    end

    // Backpressure from the first output onward
    got_log.delete();
    rdy_mode = 2;
    fork
      send_frame(basic_px, 0);
    join_none
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 0;
    wait fork;
    drain(100);
    check("bp_count", 32'(got_log.size()), 32'd4);
    if (got_log.size() == 4) begin
      check("bp_1", 32'(got_log[1]), 32'd7);
      check("bp_2", 32'(got_log[2]), 32'd9);
      check("bp_3", 32'(got_log[3]), 32'd10);
    end

    // Back-to-back frames; the first frame is large so stale buffer data would show
    got_log.delete();
    fd_count = 0;
    for (int i = 0; i < NPIX; i++) rand_px[i] = N'(16'h7000 + $urandom_range(0, 255));
    send_frame(rand_px, 0);
    for (int i = 0; i < NPIX; i++) rand_px[i] = N'($urandom_range(0, 100));
    send_frame(rand_px, 0);
    drain(100);
    check("b2b_count", 32'(got_log.size()), 32'd8);
    check("b2b_frame_done", 32'(fd_count), 32'd2);

    // Reset mid-frame
    for (int i = 0; i < 6; i++) send(basic_px[i], 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_log.delete();
    for (int i = 0; i < NPIX; i++) rand_px[i] = N'($urandom);
    send_frame(rand_px, 0);
    drain(100);
    check("rst_count", 32'(got_log.size()), 32'd4);

    // Random valid/ready toggling over 50 frames
    got_log.delete();
    fd_count = 0;
    rdy_mode = 1;
    for (int f = 0; f < 50; f++) begin
      for (int i = 0; i < NPIX; i++) rand_px[i] = N'($urandom);
      send_frame(rand_px, 30);
    end
    drain(1000);
    rdy_mode = 0;
    check("rand_count", 32'(got_log.size()), 32'd200);
    check("rand_frame_done", 32'(fd_count), 32'd50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
